// File: rtl/pc_display_sampler.sv
// pc_display_sampler
//   Sits between the cpu writeback stage and the hex display chain. Each distinct retired PC is
//   captured into a small FIFO and replayed on disp_num at a human-readable rate. Freeze plus
//   single-step is available for board debug, and PCs lost to FIFO overflow are counted.
//
// Ports
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset
//   pc_WB      writeback-stage PC
//   flush_WB   1 = writeback slot flushed, pc_WB is not a retire
//   freeze     level, 1 = stop auto-advance
//   step       level from board button, rising edge advances one entry while frozen
//   disp_num   value shown on the display digits
//   disp_valid 1 once at least one PC has been displayed
//   fifo_level entries currently buffered (0..DEPTH)
//   drop_cnt   PCs lost to overflow, saturating at 8'hFF
module pc_display_sampler #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 1 << 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        pc_WB,
  input  logic                     flush_WB,
  input  logic                     freeze,
  input  logic                     step,
  output logic [DATA_W-1:0]        disp_num,
  output logic                     disp_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(HOLD_CYCLES);

  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                valid_q, valid_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [7:0]          drop_q, drop_d;
  logic                seen_q, seen_d;
  logic [DATA_W-1:0]   last_pc_q, last_pc_d;
  logic                step_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic cap, stp, advance, pop, push, drop, fifo_empty, fifo_full;

  always_comb begin
    // A repeated PC (e.g. branch-to-self) is captured once; flushed slots are invisible.
    cap        = !flush_WB && (!seen_q || (pc_WB != last_pc_q));
    stp        = step && !step_q;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlFull);

    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    valid_d = valid_q;
    advance = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ignores freeze so the first PC after reset always shows up.
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StShow;
        end
      end
      StShow: begin
        advance = freeze ? stp : (cnt_q == CntLast);
        if (advance) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (!freeze) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      disp_d  = mem_q[rd_ptr_q];
      valid_d = 1'b1;
      cnt_d   = '0;
    end

    // Pop decisions use the pre-push level, so there is no bypass into an empty FIFO.
    push = cap && (!fifo_full || pop);
    drop = cap && fifo_full && !pop;

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    // last_pc tracks every capture, including ones that end up dropped.
    seen_d    = seen_q | cap;
    last_pc_d = cap ? pc_WB : last_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      disp_q    <= '0;
      valid_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= '0;
      seen_q    <= 1'b0;
      last_pc_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      valid_q   <= valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
      seen_q    <= seen_d;
      last_pc_q <= last_pc_d;
      step_q    <= step;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pc_WB;
    end
  end

  assign disp_num   = disp_q;
  assign disp_valid = valid_q;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_pc_display_sampler.sv
// Testbench for pc_display_sampler (DEPTH=4, HOLD_CYCLES=4): a vector table for reset and
// capture, hand-written sequences for the multi-cycle corners, and a randomized run checked
// against a queue-based reference model.
module tb_pc_display_sampler;

  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 4;
  localparam int unsigned LvlW  = $clog2(Depth) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DataW-1:0]  pc_WB;
  logic              flush_WB;
  logic              freeze;
  logic              step;
  logic [DataW-1:0]  disp_num;
  logic              disp_valid;
  logic [LvlW-1:0]   fifo_level;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  pc_display_sampler #(
    .DATA_W      (DataW),
    .DEPTH       (Depth),
    .HOLD_CYCLES (Hold)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pc_WB      (pc_WB),
    .flush_WB   (flush_WB),
    .freeze     (freeze),
    .step       (step),
    .disp_num   (disp_num),
    .disp_valid (disp_valid),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus "how long has the current value been shown".
  logic [DataW-1:0] m_q[$];
  logic [DataW-1:0] m_disp;
  logic [DataW-1:0] m_last;
  bit               m_valid, m_show, m_seen, m_step_prev;
  int               m_cnt, m_drop;

  task automatic model_reset();
    m_q.delete();
    m_disp = '0; m_last = '0;
    m_valid = 0; m_show = 0; m_seen = 0; m_step_prev = 0;
    m_cnt = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit cap, stp, adv, pop;
    cap = !flush_WB && (!m_seen || pc_WB != m_last);
    stp = step && !m_step_prev;
    pop = 0;
    if (!m_show) begin
      pop = (m_q.size() != 0);
    end else begin
      adv = freeze ? stp : (m_cnt == Hold - 1);
      if (adv && m_q.size() != 0) pop = 1;
      else if (adv) m_show = 0;
      else if (!freeze) m_cnt++;
    end
    if (pop) begin
      m_disp  = m_q.pop_front();
      m_valid = 1;
      m_show  = 1;
      m_cnt   = 0;
    end
    if (cap) begin
      m_last = pc_WB;
      m_seen = 1;
      if (m_q.size() < Depth) m_q.push_back(pc_WB);
      else if (m_drop < 255) m_drop++;
    end
    m_step_prev = step;
  endtask

  task automatic cmp_model();
    check("model_disp_num", disp_num, m_disp);
    check("model_disp_valid", disp_valid, m_valid);
    check("model_fifo_level", fifo_level, m_q.size());
    check("model_drop_cnt", drop_cnt, m_drop);
  endtask

  // Drive inputs after a falling edge, clock once, compare on the next falling edge.
  task automatic cycle(input logic [DataW-1:0] pc, input logic fl, input logic fz,
                       input logic st);
    pc_WB = pc; flush_WB = fl; freeze = fz; step = st;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_disp_num", disp_num, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [DataW-1:0] pc;
    logic             fl, fz, st;
    logic [DataW-1:0] disp;
    logic             valid;
    int               level;
    int               drop;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic fz_r, st_r;

    // Scenarios 1 and 2: first PC latency, then a constant PC captured exactly once.
    tbl[0] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 0};
    tbl[1] = '{32'h0,         1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 0, 0};
    tbl[2] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1, 0};
    tbl[3] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1, 0};
    tbl[4] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1, 0};
    tbl[5] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h100,       1'b1, 0, 0};
    tbl[6] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h100,       1'b1, 0, 0};
    tbl[7] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h100,       1'b1, 0, 0};
    tbl[8] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h100,       1'b1, 0, 0};
    tbl[9] = '{32'h100,       1'b0, 1'b0, 1'b0, 32'h100,       1'b1, 0, 0};

    pc_WB = '0; flush_WB = 1'b0; freeze = 1'b0; step = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].pc, tbl[i].fl, tbl[i].fz, tbl[i].st);
      check($sformatf("tbl%0d_disp_num", i), disp_num, tbl[i].disp);
      check($sformatf("tbl%0d_disp_valid", i), disp_valid, tbl[i].valid);
      check($sformatf("tbl%0d_fifo_level", i), fifo_level, tbl[i].level);
      check($sformatf("tbl%0d_drop_cnt", i), drop_cnt, tbl[i].drop);
    end

    // Scenario 3: back-to-back pushes replayed one value every Hold cycles.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(32'h10 + 32'(k) * 4, 1'b0, 1'b0, 1'b0);
    // After edge 4 the display holds 0x10 with 0x14..0x20 queued.
    check("s3_disp_first", disp_num, 32'h10);
    check("s3_level_full", fifo_level, 4);
    for (int k = 5; k < 24; k++) begin
      cycle(32'h20, 1'b0, 1'b0, 1'b0);
      if (k == 5)  check("s3_disp_0x14", disp_num, 32'h14);
      if (k == 8)  check("s3_disp_still_0x14", disp_num, 32'h14);
      if (k == 9)  check("s3_disp_0x18", disp_num, 32'h18);
      if (k == 17) check("s3_disp_0x20", disp_num, 32'h20);
    end
    check("s3_drop_cnt", drop_cnt, 0);
    check("s3_level_empty", fifo_level, 0);

    // Scenario 4: freeze, overflow by one, then single-step on rising edges only.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(32'hA0 + 32'(k) * 4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(32'hB4, 1'b0, 1'b1, 1'b0);
    check("s4_disp_frozen", disp_num, 32'hA0);
    check("s4_level", fifo_level, 4);
    check("s4_drop_cnt", drop_cnt, 1);
    cycle(32'hB4, 1'b0, 1'b1, 1'b1);
    check("s4_step1_disp", disp_num, 32'hA4);
    check("s4_step1_level", fifo_level, 3);
    cycle(32'hB4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(32'hB4, 1'b0, 1'b1, 1'b1);
    check("s4_held_step_disp", disp_num, 32'hA8);
    check("s4_held_step_level", fifo_level, 2);

    // Scenario 5: flushed 0xDEAD must never be captured or displayed.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle((k % 2 == 0) ? 32'hDEAD : 32'h200, (k % 2 == 0), 1'b0, 1'b0);
      if (k == 0) check("s5_flush_no_capture", fifo_level, 0);
      check("s5_dead_not_shown", (disp_num == 32'hDEAD), 0);
      check("s5_level_le_1", (fifo_level <= 1), 1);
    end
    check("s5_disp_200", disp_num, 32'h200);
    check("s5_drop_cnt", drop_cnt, 0);

    // Scenario 6: asynchronous reset mid-SHOW with three entries buffered.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(32'hC0 + 32'(k) * 4, 1'b0, 1'b1, 1'b0);
    check("s6_level_before", fifo_level, 3);
    check("s6_disp_before", disp_num, 32'hC0);
    #2 rst = 1'b0;
    #1;
    check("s6_async_disp_num", disp_num, 0);
    check("s6_async_disp_valid", disp_valid, 0);
    check("s6_async_fifo_level", fifo_level, 0);
    check("s6_async_drop_cnt", drop_cnt, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(32'h8000_0000, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 1'b1, 1'b0, 1'b0);
    check("s6_after_disp_num", disp_num, 32'h8000_0000);
    check("s6_after_disp_valid", disp_valid, 1);
    check("s6_after_fifo_level", fifo_level, 0);

    // Randomized run against the reference model.
    do_reset();
    fz_r = 1'b0;
    st_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) fz_r = ~fz_r;
      if ($urandom_range(0, 2) == 0) st_r = ~st_r;
      cycle(32'h1000 + 32'($urandom_range(0, 5)) * 4, ($urandom_range(0, 3) == 0), fz_r, st_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
